// File: rtl/stopwatch_digit_chain.sv
// N-digit up/down stopwatch chain: per-digit modulus, one-cycle carry/borrow ripple, preset, adjust, run/pause/done control.
// Optional build macro STOPWATCH_CHAIN_SAT_EN: up mode saturates at all-max instead of rolling over.
module stopwatch_digit_chain #(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_W = 4,
    parameter logic [NUM_DIGITS*DIGIT_W-1:0] MAX_VEC = {4'd5, 4'd9, 4'd5, 4'd9},
    parameter logic [NUM_DIGITS*DIGIT_W-1:0] PRESET_VEC = {4'd0, 4'd1, 4'd0, 4'd0},
    localparam int SEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          tick,
    input  logic                          start_stop,
    input  logic                          ups,
    input  logic                          load,
    input  logic                          clear,
    input  logic                          adj,
    input  logic [SEL_W-1:0]              adj_sel,
    output logic [NUM_DIGITS*DIGIT_W-1:0] digits,
    output logic                          running,
    output logic                          wrap,
    output logic                          done
);

    localparam int W = NUM_DIGITS * DIGIT_W;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

    state_t           state, state_next;
    logic [W-1:0]     digits_next, count_up, count_dn, adj_val;
    logic             wrap_next, done_next;
    logic             all_max, dn_zero, carry, borrow, adj_ok;
    logic [DIGIT_W-1:0] d, m, ad, am;
    int               sel_idx;

    // Full ripple in one pass; a digit above its max is treated as at-max.
    always_comb begin
        count_up = digits;
        count_dn = digits;
        carry    = 1'b1;
        borrow   = 1'b1;
        all_max  = 1'b1;
        d        = '0;
        m        = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            d = digits[i*DIGIT_W +: DIGIT_W];
            m = MAX_VEC[i*DIGIT_W +: DIGIT_W];
            if (d < m) all_max = 1'b0;
            if (carry) begin
                if (d >= m) begin
                    count_up[i*DIGIT_W +: DIGIT_W] = '0;
                end else begin
                    count_up[i*DIGIT_W +: DIGIT_W] = d + 1'b1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (d == '0) begin
                    count_dn[i*DIGIT_W +: DIGIT_W] = m;
                end else begin
                    count_dn[i*DIGIT_W +: DIGIT_W] = d - 1'b1;
                    borrow = 1'b0;
                end
            end
        end
        dn_zero = (count_dn == '0);
    end

    // Manual adjust wraps within the selected digit only; neighbours are untouched.
    always_comb begin
        sel_idx = int'(adj_sel);
        adj_ok  = (sel_idx < NUM_DIGITS);
        adj_val = digits;
        ad      = '0;
        am      = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i == sel_idx) begin
                ad = digits[i*DIGIT_W +: DIGIT_W];
                am = MAX_VEC[i*DIGIT_W +: DIGIT_W];
                if (ups) adj_val[i*DIGIT_W +: DIGIT_W] = (ad >= am) ? '0 : ad + 1'b1;
                else     adj_val[i*DIGIT_W +: DIGIT_W] = (ad == '0) ? am : ad - 1'b1;
            end
        end
    end

    always_comb begin
        state_next  = state;
        digits_next = digits;
        wrap_next   = 1'b0;
        done_next   = 1'b0;
        if (clear) begin
            digits_next = '0;
            state_next  = S_IDLE;
        end else if (load) begin
            digits_next = PRESET_VEC;
            state_next  = S_IDLE;
        end else if (adj && adj_ok && state != S_RUN) begin
            digits_next = adj_val;
            if (state == S_DONE) state_next = S_IDLE;
        end else begin
            if (start_stop) begin
                case (state)
                    S_IDLE, S_PAUSE: if (ups || digits != '0) state_next = S_RUN;
                    S_RUN:           state_next = S_PAUSE;
                    default:         state_next = state;
                endcase
            end
            // Tick is judged against the state before any start_stop toggle.
            if (tick && state == S_RUN) begin
                if (ups) begin
`ifdef STOPWATCH_CHAIN_SAT_EN
                    if (all_max) begin
                        state_next = S_DONE;
                        done_next  = 1'b1;
                    end else begin
                        digits_next = count_up;
                    end
`else
                    digits_next = count_up;
                    wrap_next   = all_max;
`endif
                end else begin
                    digits_next = count_dn;
                    if (dn_zero) begin
                        state_next = S_DONE;
                        done_next  = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            digits  <= '0;
            running <= 1'b0;
            wrap    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_next;
            digits  <= digits_next;
            running <= (state_next == S_RUN);
            wrap    <= wrap_next;
            done    <= done_next;
        end
    end

endmodule
